// File: rtl/rom_4x3.sv
// rom_4x3: fixed-content 4-word x 3-bit lookup table.
// Synchronous read with one cycle of latency. The read word appears on
// D2 (MSB), D1 and D0 (LSB), and valid marks the cycle that follows an
// accepted read. The contents are fixed at elaboration through parameters.
module rom_4x3 #(
   parameter logic [2:0] WORD0 = 3'b101,
   parameter logic [2:0] WORD1 = 3'b011,
   parameter logic [2:0] WORD2 = 3'b110,
   parameter logic [2:0] WORD3 = 3'b001
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd_en,
   input  logic [1:0] addr,
   output logic       D2,
   output logic       D1,
   output logic       D0,
   output logic       valid
);

   // Maps an address to its stored word. An unknown address falls back to
   // WORD0, so the decode never leaves a path that could infer a latch.
   function automatic logic [2:0] lookup(input logic [1:0] a);
      logic [2:0] w;
      case (a)
         2'd0:    w = WORD0;
         2'd1:    w = WORD1;
         2'd2:    w = WORD2;
         2'd3:    w = WORD3;
         default: w = WORD0;
      endcase
      return w;
   endfunction

   logic [2:0] word_p1;
   logic       vld_p1;

   // Stage p1: register the looked-up word and the read flag. Reset takes
   // priority over a read, and the data holds its value while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_p1 <= 3'b000;
         vld_p1  <= 1'b0;
      end else if (rd_en) begin
         word_p1 <= lookup(addr);
         vld_p1  <= 1'b1;
      end else begin
         vld_p1  <= 1'b0;
      end
   end

   assign D2    = word_p1[2];
   assign D1    = word_p1[1];
   assign D0    = word_p1[0];
   assign valid = vld_p1;

endmodule

// File: tb/tb_rom_4x3.sv
// tb_rom_4x3: drives a default-content instance and a parameter-override
// instance with the same stimulus. Each instance is compared against its
// own table-driven reference of the read/idle/reset rules.
`timescale 1ns/1ps
module tb_rom_4x3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rd_en = 1'b0;
   logic [1:0] addr = 2'd0;

   logic       d2_a, d1_a, d0_a, valid_a;
   logic       d2_b, d1_b, d0_b, valid_b;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference contents for each instance.
   logic [2:0] rom_a [4] = '{3'b101, 3'b011, 3'b110, 3'b001};
   logic [2:0] rom_b [4] = '{3'b000, 3'b111, 3'b010, 3'b100};

   // Reference output state, as {valid, D2, D1, D0}.
   logic [3:0] exp_a, exp_b;

   always #5 clk = ~clk;

   rom_4x3 u_def (
      .clk   (clk),
      .rst   (rst),
      .rd_en (rd_en),
      .addr  (addr),
      .D2    (d2_a),
      .D1    (d1_a),
      .D0    (d0_a),
      .valid (valid_a)
   );

   rom_4x3 #(
      .WORD0 (3'b000),
      .WORD1 (3'b111),
      .WORD2 (3'b010),
      .WORD3 (3'b100)
   ) u_ovr (
      .clk   (clk),
      .rst   (rst),
      .rd_en (rd_en),
      .addr  (addr),
      .D2    (d2_b),
      .D1    (d1_b),
      .D0    (d0_b),
      .valid (valid_b)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got {valid,D2,D1,D0}=%b, expected %b", tag, obs, exp);
      end
   endtask

   // Applies one cycle of inputs, advances the reference, and checks both instances.
   task automatic step(input logic r, input logic re, input logic [1:0] a, input string tag);
      @(negedge clk);
      rst   = r;
      rd_en = re;
      addr  = a;
      @(posedge clk);
      if (r) begin
         exp_a = 4'b0000;
         exp_b = 4'b0000;
      end else if (re) begin
         exp_a = {1'b1, rom_a[a]};
         exp_b = {1'b1, rom_b[a]};
      end else begin
         exp_a[3] = 1'b0;
         exp_b[3] = 1'b0;
      end
      #1;
      chk({tag, "_def"}, {valid_a, d2_a, d1_a, d0_a}, exp_a);
      chk({tag, "_ovr"}, {valid_b, d2_b, d1_b, d0_b}, exp_b);
   endtask

   initial begin
      exp_a = 4'b0000;
      exp_b = 4'b0000;

      // Reset held for two cycles while a read is requested.
      step(1'b1, 1'b1, 2'd2, "reset0");
      step(1'b1, 1'b1, 2'd2, "reset1");
      step(1'b0, 1'b0, 2'd2, "post_reset");
      chk("post_reset_const", {valid_a, d2_a, d1_a, d0_a}, 4'b0000);

      // Sequential sweep of all four addresses.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 2'(i), "sweep");
      end
      chk("sweep_last_def", {valid_a, d2_a, d1_a, d0_a}, 4'b1001);
      chk("sweep_last_ovr", {valid_b, d2_b, d1_b, d0_b}, 4'b1100);

      // Hold the data while idle and addr toggles.
      step(1'b0, 1'b1, 2'd2, "hold_rd");
      chk("hold_rd_const", {valid_a, d2_a, d1_a, d0_a}, 4'b1110);
      step(1'b0, 1'b0, 2'd0, "hold0");
      step(1'b0, 1'b0, 2'd3, "hold1");
      step(1'b0, 1'b0, 2'd0, "hold2");
      chk("hold_const", {valid_a, d2_a, d1_a, d0_a}, 4'b0110);

      // Reset arrives mid-stream, on the cycle that presents addr 0.
      step(1'b0, 1'b1, 2'd3, "mid_rd3");
      step(1'b0, 1'b1, 2'd1, "mid_rd1");
      step(1'b1, 1'b1, 2'd0, "mid_rst");
      chk("mid_rst_const", {valid_a, d2_a, d1_a, d0_a}, 4'b0000);
      step(1'b0, 1'b1, 2'd0, "mid_after");
      chk("mid_after_const", {valid_a, d2_a, d1_a, d0_a}, 4'b1101);

      // Random traffic with occasional reset.
      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion", n_chk);
      $fatal(1, "timeout");
   end

endmodule
